// File: rtl/fp_writeback_buffer_if.sv
// Handshake bundle between the FP unit, the writeback buffer and the FP register file.
// The buffer takes the slave view; the FP unit and register file side takes the master view.
interface fp_writeback_buffer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     fp_result;
    logic                      fp_overflow;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic                      wb_overflow;
    logic                      flag_overflow;
    logic                      flag_clear;
    logic [CNT_W-1:0]          count;

    modport master (
        output in_valid, fp_result, fp_overflow, rd_addr, wb_ready, flag_clear,
        input  in_ready, wb_valid, wb_data, wb_addr, wb_overflow, flag_overflow, count
    );

    modport slave (
        input  in_valid, fp_result, fp_overflow, rd_addr, wb_ready, flag_clear,
        output in_ready, wb_valid, wb_data, wb_addr, wb_overflow, flag_overflow, count
    );
endinterface

// File: rtl/fp_writeback_buffer.sv
// In-order FIFO of FP results (writes to x0 dropped) feeding the register file; one-cycle minimum latency, no bypass.
// Backpressure: in_ready drops only when all DEPTH entries are full, independent of wb_ready; sticky overflow flag.
module fp_writeback_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_writeback_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0]     r_data [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic                      r_ovf  [DEPTH];
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic                      r_flag;

    logic w_in_ready;
    logic w_wb_valid;
    logic w_accept;
    logic w_store;
    logic w_retire;

    assign w_in_ready = (r_count != CNT_W'(DEPTH));
    assign w_wb_valid = (r_count != '0);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_store    = w_accept && (bus.rd_addr != '0);
    assign w_retire   = w_wb_valid && bus.wb_ready;

    // Entry storage is never visible while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_data[r_tail] <= bus.fp_result;
            r_addr[r_tail] <= bus.rd_addr;
            r_ovf[r_tail]  <= bus.fp_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_retire) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_store, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A setting accept takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (w_accept && bus.fp_overflow) begin
            r_flag <= 1'b1;
        end else if (bus.flag_clear) begin
            r_flag <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.wb_valid      = w_wb_valid;
    assign bus.wb_data       = w_wb_valid ? r_data[r_head] : '0;
    assign bus.wb_addr       = w_wb_valid ? r_addr[r_head] : '0;
    assign bus.wb_overflow   = w_wb_valid ? r_ovf[r_head]  : 1'b0;
    assign bus.flag_overflow = r_flag;
    assign bus.count         = r_count;
endmodule

// File: tb/tb_fp_writeback_buffer.sv
// Scoreboarded bench for fp_writeback_buffer: inputs change 1ns after the rising edge,
// state is checked right after that, and retired entries are compared on the falling edge.
module tb_fp_writeback_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = DW + AW + 1;

    logic clk;
    logic rst_n;

    fp_writeback_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) bus ();

    fp_writeback_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    logic m_flag = 1'b0;
    logic [EW-1:0] sb[$];

    // Retire-side scoreboard: every entry leaving the buffer must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && bus.wb_valid && bus.wb_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected: got data=%h addr=%0d ovf=%b, required no retire (queue empty)",
                         bus.wb_data, bus.wb_addr, bus.wb_overflow);
            end else begin
                logic [EW-1:0] exp;
                exp = sb.pop_front();
                if ({bus.wb_data, bus.wb_addr, bus.wb_overflow} !== exp) begin
                    n_fail++;
                    $display("FAIL retire_order: got data=%h addr=%0d ovf=%b, required data=%h addr=%0d ovf=%b",
                             bus.wb_data, bus.wb_addr, bus.wb_overflow,
                             exp[EW-1 -: DW], exp[AW:1], exp[0]);
                end
            end
        end
    end

    // Drives one cycle of stimulus, advances the reference model, and returns 1ns after the edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic o, input logic wr, input logic clr);
        logic acc, st, ret;
        bus.in_valid    = v;
        bus.fp_result   = d;
        bus.rd_addr     = a;
        bus.fp_overflow = o;
        bus.wb_ready    = wr;
        bus.flag_clear  = clr;
        acc = v && (m_cnt < DEPTH);
        st  = acc && (a != '0);
        ret = (m_cnt > 0) && wr;
        if (st) sb.push_back({d, a, o});
        m_cnt = m_cnt + int'(st) - int'(ret);
        if (acc && o) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wr);
        drive(1'b0, '0, '0, 1'b0, wr, 1'b0);
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", bus.count); end
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b, required 0", bus.wb_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.flag_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b, required 0", bus.flag_overflow); end
        if ({bus.wb_data, bus.wb_addr, bus.wb_overflow} !== '0) begin
            n_fail++; $display("FAIL reset_wb_bus: got data=%h addr=%0d, required 0", bus.wb_data, bus.wb_addr);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h3F80_0000, 5'd3, 1'b0, 1'b1, 1'b0);
        n_checks += 4;
        if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, required 1", bus.wb_valid); end
        if (bus.wb_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data: got %h, required 3f800000", bus.wb_data); end
        if (bus.wb_addr !== 5'd3) begin n_fail++; $display("FAIL single_addr: got %0d, required 3", bus.wb_addr); end
        if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL single_count1: got %0d, required 1", bus.count); end
        idle(1'b1);
        n_checks += 3;
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b, required 0", bus.wb_valid); end
        if (bus.count !== '0) begin n_fail++; $display("FAIL single_count0: got %0d, required 0", bus.count); end
        if (bus.wb_data !== '0) begin n_fail++; $display("FAIL single_data_zero: got %h, required 0", bus.wb_data); end
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 32'h1000 + i, AW'(i), 1'b0, 1'b0, 1'b0);
        n_checks += 3;
        if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d, required %0d", bus.count, DEPTH); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.wb_addr !== 5'd1) begin n_fail++; $display("FAIL fill_head: got %0d, required 1", bus.wb_addr); end
        drive(1'b1, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0);
        n_checks += 3;
        if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_ignored: got %0d, required %0d", bus.count, DEPTH); end
        if (bus.wb_data !== 32'h1001) begin n_fail++; $display("FAIL stall_hold: got %h, required 00001001", bus.wb_data); end
        if (bus.flag_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_flag: got %b, required 0", bus.flag_overflow); end
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL fill_drain: got %0d, required 0", bus.count); end
    endtask

    task automatic test_x0_discard();
        drive(1'b1, 32'h4000_0000, 5'd0, 1'b1, 1'b0, 1'b0);
        n_checks += 3;
        if (bus.count !== '0) begin n_fail++; $display("FAIL x0_count: got %0d, required 0", bus.count); end
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL x0_valid: got %b, required 0", bus.wb_valid); end
        if (bus.flag_overflow !== 1'b1) begin n_fail++; $display("FAIL x0_flag: got %b, required 1", bus.flag_overflow); end
    endtask

    task automatic test_sticky_flag();
        drive(1'b1, 32'h0000_0011, 5'd9, 1'b1, 1'b0, 1'b1);
        n_checks += 2;
        if (bus.flag_overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b, required 1", bus.flag_overflow); end
        if (bus.wb_overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_entry_ovf: got %b, required 1", bus.wb_overflow); end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        n_checks += 2;
        if (bus.flag_overflow !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b, required 0", bus.flag_overflow); end
        if (bus.count !== '0) begin n_fail++; $display("FAIL sticky_count: got %0d, required 0", bus.count); end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, 32'h2000 + i, AW'(10 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h2100, 5'd20, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL bnd_full_minus1: got %0d, required %0d", bus.count, DEPTH - 1); end
        idle(1'b1);
        idle(1'b1);
        n_checks++;
        if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL bnd_drain_to1: got %0d, required 1", bus.count); end
        drive(1'b1, 32'h2200, 5'd21, 1'b1, 1'b1, 1'b0);
        n_checks += 2;
        if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL bnd_one: got %0d, required 1", bus.count); end
        if (bus.wb_addr !== 5'd21) begin n_fail++; $display("FAIL bnd_one_head: got %0d, required 21", bus.wb_addr); end
        idle(1'b1);
    endtask

    task automatic test_stream_wrap();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h5000 + i, AW'((i * 3) % 8), (i == 5), (i % 2 == 0), 1'b0);
            n_checks++;
            if (bus.count !== CW'(m_cnt) || bus.count > CW'(DEPTH)) begin
                n_fail++; $display("FAIL stream_count[%0d]: got %0d, required %0d", i, bus.count, m_cnt);
            end
        end
        for (int k = 0; k < 2 * DEPTH && m_cnt > 0; k++) idle(1'b1);
        n_checks += 2;
        if (bus.count !== '0) begin n_fail++; $display("FAIL stream_drain: got %0d, required 0", bus.count); end
        if (bus.flag_overflow !== m_flag) begin n_fail++; $display("FAIL stream_flag: got %b, required %b", bus.flag_overflow, m_flag); end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) drive(1'b1, 32'h6000 + i, AW'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL arst_pre_count: got %0d, required 3", bus.count); end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        m_cnt  = 0;
        m_flag = 1'b0;
        n_checks += 4;
        if (bus.count !== '0) begin n_fail++; $display("FAIL arst_count: got %0d, required 0", bus.count); end
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b, required 0", bus.wb_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.wb_data !== '0) begin n_fail++; $display("FAIL arst_data: got %h, required 0", bus.wb_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 32'hA5A5_0001, 5'd7, 1'b0, 1'b1, 1'b0);
        n_checks += 2;
        if (bus.wb_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL arst_first_data: got %h, required a5a50001", bus.wb_data); end
        if (bus.wb_addr !== 5'd7) begin n_fail++; $display("FAIL arst_first_addr: got %0d, required 7", bus.wb_addr); end
        idle(1'b1);
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL arst_drain: got %0d, required 0", bus.count); end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.fp_result   = '0;
        bus.fp_overflow = 1'b0;
        bus.rd_addr     = '0;
        bus.wb_ready    = 1'b0;
        bus.flag_clear  = 1'b0;
        #3;
        test_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_single();
        test_fill_stall();
        test_x0_discard();
        test_sticky_flag();
        test_boundary();
        test_stream_wrap();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
